// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall controller: stall bit indices,
// stall patterns, multi-cycle sequencer state encodings and polarity constants.
package pipe_ctrl_pkg;

    localparam logic Stop      = 1'b1;
    localparam logic NoStop    = 1'b0;
    localparam logic RstEnable = 1'b1;

    localparam int STALL_PC     = 0;
    localparam int STALL_IF_ID  = 1;
    localparam int STALL_ID_EX  = 2;
    localparam int STALL_EX_MEM = 3;
    localparam int STALL_MEM_WB = 4;
    localparam int STALL_SPARE  = 5;

    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_IF   = 6'b000011;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;

    typedef enum logic [1:0] {
        MC_IDLE = 2'd0,
        MC_BUSY = 2'd1,
        MC_DONE = 2'd2
    } mc_state_e;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Request/stall bundle between the pipeline stages and pipe_ctrl.
// The master drives the stall requests; the slave (pipe_ctrl) drives stall and status.
interface pipe_ctrl_if #(
    parameter int CNT_W  = 6,
    parameter int PERF_W = 32
);
    import pipe_ctrl_pkg::*;

    logic              stallreq_if;
    logic              stallreq_id;
    logic              mc_start;
    logic [CNT_W-1:0]  mc_cycles;
    logic [5:0]        stall;
    logic              mc_busy;
    logic              mc_done;
    logic [CNT_W-1:0]  mc_remain;
    logic [PERF_W-1:0] stall_cycles;
    mc_state_e         mc_state;

    modport master (
        output stallreq_if, stallreq_id, mc_start, mc_cycles,
        input  stall, mc_busy, mc_done, mc_remain, stall_cycles, mc_state
    );

    modport slave (
        input  stallreq_if, stallreq_id, mc_start, mc_cycles,
        output stall, mc_busy, mc_done, mc_remain, stall_cycles, mc_state
    );

endinterface

// File: rtl/pipe_ctrl_mc_sequencer.sv
// Multi-cycle EX operation sequencer: IDLE -> BUSY (countdown N) -> DONE -> IDLE.
// Holds the EX stall from acceptance until the DONE cycle.
module mc_sequencer
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mc_start_i,
    input  logic [CNT_W-1:0] mc_cycles_i,
    output logic             ex_req_o,
    output logic             mc_busy_o,
    output logic             mc_done_o,
    output logic [CNT_W-1:0] mc_remain_o,
    output mc_state_e        state_o
);

    mc_state_e        state_q, state_d;
    logic [CNT_W-1:0] remain_q, remain_d;

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q  <= MC_IDLE;
            remain_q <= '0;
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        case (state_q)
            MC_IDLE: begin
                if (mc_start_i) begin
                    // A zero length would never reach DONE; run it as one cycle.
                    remain_d = (mc_cycles_i == '0) ? CNT_W'(1) : mc_cycles_i;
                    state_d  = MC_BUSY;
                end
            end
            MC_BUSY: begin
                remain_d = remain_q - CNT_W'(1);
                if (remain_q <= CNT_W'(1)) begin
                    state_d = MC_DONE;
                end
            end
            MC_DONE: begin
                state_d = MC_IDLE;
            end
            default: begin
                state_d  = MC_IDLE;
                remain_d = '0;
            end
        endcase
    end

    assign ex_req_o    = ((state_q == MC_IDLE) && mc_start_i) || (state_q == MC_BUSY);
    assign mc_busy_o   = (state_q == MC_BUSY);
    assign mc_done_o   = (state_q == MC_DONE);
    assign mc_remain_o = remain_q;
    assign state_o     = state_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall controller: priority-encodes EX/ID/IF stall requests into the
// per-stage stall vector and counts stalled cycles with a saturating counter.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W  = 6,
    parameter int PERF_W = 32
) (
    input  logic        clk,
    input  logic        rst,
    pipe_ctrl_if.slave  bus
);

    logic              ex_req;
    logic              mc_busy;
    logic              mc_done;
    logic [CNT_W-1:0]  mc_remain;
    mc_state_e         mc_state;
    logic [5:0]        stall_vec;
    logic [PERF_W-1:0] perf_q, perf_d;

    mc_sequencer #(.CNT_W(CNT_W)) u_mc_sequencer (
        .clk         (clk),
        .rst         (rst),
        .mc_start_i  (bus.mc_start),
        .mc_cycles_i (bus.mc_cycles),
        .ex_req_o    (ex_req),
        .mc_busy_o   (mc_busy),
        .mc_done_o   (mc_done),
        .mc_remain_o (mc_remain),
        .state_o     (mc_state)
    );

    // Highest stage wins: an EX stall also freezes everything upstream of it.
    always_comb begin
        stall_vec = STALL_NONE;
        if (ex_req) begin
            stall_vec = STALL_EX;
        end else if (bus.stallreq_id) begin
            stall_vec = STALL_ID;
        end else if (bus.stallreq_if) begin
            stall_vec = STALL_IF;
        end
    end

    always_comb begin
        perf_d = perf_q;
        if ((stall_vec[STALL_PC] == Stop) && (perf_q != {PERF_W{1'b1}})) begin
            perf_d = perf_q + PERF_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign bus.stall        = stall_vec;
    assign bus.mc_busy      = mc_busy;
    assign bus.mc_done      = mc_done;
    assign bus.mc_remain    = mc_remain;
    assign bus.mc_state     = mc_state;
    assign bus.stall_cycles = perf_q;

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline stall controller for the five-stage MIPS32 core. It merges stall requests from IF and ID with the occupancy of a multi-cycle EX operation sequencer and drives the `stall` vector consumed by pc_reg, if_id, id_ex, ex_mem and mem_wb. It also keeps a saturating stalled-cycle performance counter.

## Interface
Parameters:
- `CNT_W`, default 6: width of the multi-cycle length and its countdown counter.
- `PERF_W`, default 32: width of the stall performance counter.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `stallreq_if`  in  1  instruction fetch not ready.
- `stallreq_id`  in  1  load-use hazard detected in ID.
- `mc_start`  in  1  EX holds a multi-cycle op (div/madd). Level signal, held while the op is in EX.
- `mc_cycles`  in  CNT_W  op length N, sampled at acceptance.
- `stall`  out  6  bit0 pc, bit1 if_id, bit2 id_ex, bit3 ex_mem, bit4 mem_wb, bit5 spare. 1 = `Stop`.
- `mc_busy`  out  1  sequencer in BUSY.
- `mc_done`  out  1  one-cycle completion strobe; EX result valid this cycle.
- `mc_remain`  out  CNT_W  remaining BUSY cycles.
- `stall_cycles`  out  PERF_W  count of cycles with stall[0]=1, saturating.

## Operation
- Sequencer FSM states: IDLE, BUSY, DONE.
  - IDLE: when `mc_start`=1, load `mc_remain` with N (N=0 is treated as 1) and go to BUSY.
  - BUSY: decrement `mc_remain` each cycle. When `mc_remain`=1, go to DONE; the decrement takes it to 0.
  - DONE: `mc_done`=1 and the EX stall is released. Always return to IDLE next cycle. `mc_start` is ignored in DONE.
- `mc_start` is ignored in BUSY. No new op is accepted until IDLE.
- Internal EX request `ex_req` = (IDLE & mc_start) | BUSY.
- `stall` is combinational, with highest-stage priority:
  - `ex_req` → 6'b001111. ex_mem captures a bubble; id_ex holds.
  - else `stallreq_id` → 6'b000111. id_ex inserts a NOP.
  - else `stallreq_if` → 6'b000011.
  - else 6'b000000.
- bit4 and bit5 are always 0.
- `stall_cycles` increments on every edge where stall[0]=1 and stops at all-ones.
- `mc_busy` = (state==BUSY). `mc_done` = (state==DONE). Both are decoded from registered state, with no input paths.

## Timing
- Reset values: state IDLE, `mc_remain` 0, `mc_busy` 0, `mc_done` 0, `stall_cycles` 0. `stall` = 0 when all requests are low.
- `rst` mid-operation (BUSY or DONE) returns to IDLE at the next edge. The pending op is dropped and no `mc_done` is produced.
- Op accepted in cycle t with length N:
  - stall[3:0]=1111 in cycles t..t+N.
  - `mc_busy` is high in cycles t+1..t+N.
  - `mc_done` and released stall occur in cycle t+N+1.
  - The instruction enters MEM at the end of t+N+1.
- Total EX occupancy is N+2 cycles.
- If `stallreq_id` or `stallreq_if` is high during DONE, the lower-priority pattern applies. id_ex still advances, and the op completes normally.
- Zero-cycle combinational path: requests → `stall`. No path from `mc_cycles` to `stall`.

## Structure
- The shared defines file carries:
  - stall bit indices and patterns `STALL_NONE`, `STALL_IF`, `STALL_ID`, `STALL_EX`;
  - state encodings `MC_IDLE`, `MC_BUSY`, `MC_DONE` (2 bits);
  - `Stop`/`NoStop`, `RstEnable`.
- One sub-module, `mc_sequencer` (FSM plus countdown), outputs `ex_req`, `mc_busy`, `mc_done`, `mc_remain`.
- The top level holds the priority encoder and the perf counter.

## Test plan
- Reset: hold `rst` 2 cycles with all requests high → after release, state IDLE and `stall_cycles`=0. During reset `stall` is 6'b001111 (combinational).
- Priority: `stallreq_if`=1 alone → 6'b000011. Add `stallreq_id` → 6'b000111. Add `mc_start` in IDLE → 6'b001111.
- Multi-cycle op: `mc_start`=1 with `mc_cycles`=3 at t → `mc_busy` high t+1..t+3, `mc_remain` 3,2,1 then 0 in DONE, `mc_done` only at t+4, stall[3:0]=1111 for t..t+3. Keep `mc_start` high through t+4 → no re-acceptance at t+4.
- N=0: `mc_cycles`=0 → behaves as N=1. Exactly one BUSY cycle, then `mc_done` the next cycle.
- Reset mid-op: `mc_cycles`=32 (6'b100000), assert `rst` at t+5 → IDLE at t+6, `mc_done` never asserted, `stall` = 0 with inputs low.
- Perf counter: force `PERF_W`=4 and hold `stallreq_if` for 20 cycles → `stall_cycles` saturates at 4'hF and stays there.
